// File: rtl/sha256_pkg.sv
// Shared SHA-2 accelerator types: transaction-ID width and ID type used by issuer, ID buffer and concatenator.
package sha256_pkg;
    localparam int ID_W_DEF = 6;
    typedef logic [ID_W_DEF-1:0] id_t;
endpackage

// File: rtl/sha256_id_issue.sv
// Issues a gap-free modulo-2^ID_W ID sequence to two consumers (cfg, buf); zero-latency valids from registered state.
// An ID retires only once both channels have handshaken; en low masks valids and freezes all state.
module sha256_id_issue
    import sha256_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic            en,
    output logic [ID_W-1:0] id_out,
    output logic            id_out_last,
    output logic            id_out_cfg_valid,
    input  logic            id_out_cfg_ready,
    output logic            id_out_buf_valid,
    input  logic            id_out_buf_ready
);

    logic [ID_W-1:0] id_q;
    logic            cfg_pend;
    logic            buf_pend;
    logic            hs_c;
    logic            hs_b;
    logic            retire;

    assign id_out           = id_q;
    assign id_out_last      = 1'b1;
    assign id_out_cfg_valid = cfg_pend & en;
    assign id_out_buf_valid = buf_pend & en;

    assign hs_c = id_out_cfg_valid & id_out_cfg_ready;
    assign hs_b = id_out_buf_valid & id_out_buf_ready;

    // A channel that already took the ID counts as done; at least one handshake must land this cycle.
    assign retire = (hs_c | ~cfg_pend) & (hs_b | ~buf_pend) & (hs_c | hs_b);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            id_q     <= '0;
            cfg_pend <= 1'b1;
            buf_pend <= 1'b1;
        end else if (en) begin
            if (retire) begin
                id_q     <= id_q + 1'b1;
                cfg_pend <= 1'b1;
                buf_pend <= 1'b1;
            end else begin
                if (hs_c) cfg_pend <= 1'b0;
                if (hs_b) buf_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_id_issue.sv
// Directed bench for sha256_id_issue: reset, back-to-back issue, wrap, stalls, en freeze, mid-delivery reset, random stalls.
module tb_sha256_id_issue;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic       en;
    logic [5:0] id_out;
    logic       id_out_last;
    logic       id_out_cfg_valid;
    logic       id_out_cfg_ready;
    logic       id_out_buf_valid;
    logic       id_out_buf_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sha256_id_issue #(.ID_W(6)) dut (
        .clk              (clk),
        .sync_rst         (sync_rst),
        .en               (en),
        .id_out           (id_out),
        .id_out_last      (id_out_last),
        .id_out_cfg_valid (id_out_cfg_valid),
        .id_out_cfg_ready (id_out_cfg_ready),
        .id_out_buf_valid (id_out_buf_valid),
        .id_out_buf_ready (id_out_buf_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled just after the falling edge, once new inputs have settled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [5:0] id, input logic cv, input logic bv);
        chk({tag, "_id"}, {26'd0, id_out}, {26'd0, id});
        chk({tag, "_cfg_vld"}, {31'd0, id_out_cfg_valid}, {31'd0, cv});
        chk({tag, "_buf_vld"}, {31'd0, id_out_buf_valid}, {31'd0, bv});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int exp_c;
        int exp_b;
        int sc;
        int sb;
        int cyc;

        sync_rst         = 1'b1;
        en               = 1'b0;
        id_out_cfg_ready = 1'b0;
        id_out_buf_ready = 1'b0;
        @(negedge clk);
        tick();
        do_reset();

        // Reset state, then back-to-back issue over the wrap point.
        en               = 1'b1;
        id_out_cfg_ready = 1'b1;
        id_out_buf_ready = 1'b1;
        #1;
        chk_state("reset", 6'd0, 1'b1, 1'b1);
        chk("reset_last", {31'd0, id_out_last}, 32'd1);
        for (int i = 0; i < 66; i++) begin
            logic [5:0] e;
            e = 6'(i % 64);
            chk_state($sformatf("b2b%0d", i), e, 1'b1, 1'b1);
            chk($sformatf("b2b%0d_last", i), {31'd0, id_out_last}, 32'd1);
            tick();
        end
        chk_state("after_wrap", 6'd2, 1'b1, 1'b1);

        // cfg accepts ID 0, buf stalls 5 cycles.
        do_reset();
        id_out_buf_ready = 1'b0;
        #1;
        chk_state("stall_c0", 6'd0, 1'b1, 1'b1);
        tick();
        for (int i = 1; i < 5; i++) begin
            chk_state($sformatf("stall_c%0d", i), 6'd0, 1'b0, 1'b1);
            tick();
        end
        id_out_buf_ready = 1'b1;
        #1;
        chk_state("stall_bacc", 6'd0, 1'b0, 1'b1);
        tick();
        chk_state("stall_next", 6'd1, 1'b1, 1'b1);

        // buf takes ID 9, then en drops for 4 cycles.
        do_reset();
        repeat (9) tick();
        chk_state("en_at9", 6'd9, 1'b1, 1'b1);
        id_out_cfg_ready = 1'b0;
        #1;
        tick();
        chk_state("en_btook9", 6'd9, 1'b1, 1'b0);
        en               = 1'b0;
        id_out_cfg_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_state($sformatf("en_off%0d", i), 6'd9, 1'b0, 1'b0);
            tick();
        end
        en               = 1'b1;
        id_out_cfg_ready = 1'b0;
        #1;
        chk_state("en_resume", 6'd9, 1'b1, 1'b0);
        tick();
        chk_state("en_hold", 6'd9, 1'b1, 1'b0);
        id_out_cfg_ready = 1'b1;
        #1;
        tick();
        chk_state("en_next", 6'd10, 1'b1, 1'b1);

        // Reset while ID 37 is half-delivered, with a buf handshake offered in the reset cycle.
        do_reset();
        repeat (37) tick();
        chk_state("rst_at37", 6'd37, 1'b1, 1'b1);
        id_out_buf_ready = 1'b0;
        #1;
        tick();
        chk_state("rst_half", 6'd37, 1'b0, 1'b1);
        id_out_buf_ready = 1'b1;
        do_reset();
        chk_state("rst_mid", 6'd0, 1'b1, 1'b1);

        // Independent random stalls (0-7 cycles) per channel over 200 IDs.
        do_reset();
        exp_c = 0;
        exp_b = 0;
        sc    = $urandom_range(0, 7);
        sb    = $urandom_range(0, 7);
        cyc   = 0;
        while ((exp_c < 200 || exp_b < 200) && cyc < 5000) begin
            id_out_cfg_ready = (sc == 0);
            id_out_buf_ready = (sb == 0);
            #1;
            if (id_out_cfg_valid && id_out_cfg_ready) begin
                chk($sformatf("rnd_cfg%0d", exp_c), {26'd0, id_out}, 32'(exp_c % 64));
                exp_c++;
                sc = $urandom_range(0, 7);
            end else if (sc > 0) begin
                sc--;
            end
            if (id_out_buf_valid && id_out_buf_ready) begin
                chk($sformatf("rnd_buf%0d", exp_b), {26'd0, id_out}, 32'(exp_b % 64));
                exp_b++;
                sb = $urandom_range(0, 7);
            end else if (sb > 0) begin
                sb--;
            end
            tick();
            cyc++;
        end
        chk("rnd_cfg_done", {31'd0, exp_c >= 200}, 32'd1);
        chk("rnd_buf_done", {31'd0, exp_b >= 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_id_issue.md
# sha256_id_issue

Transaction-ID issuer for the SHA-2 accelerator. Generates a free-running 6-bit ID sequence and offers each ID simultaneously to two consumers: the configuration/concatenator path (cfg) and the ID buffer (buf). An ID is retired only after both consumers have accepted it, so both see the identical, gap-free sequence.

## Interface

Parameters:
- ID_W, default 6, width of the issued ID; the sequence wraps modulo 2^ID_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- sync_rst  in  1  reset; synchronous, active-high.
- en  in  1  issue enable; 0 masks both valids and freezes all state.
- id_out  out  ID_W  current ID, shared by both channels.
- id_out_last  out  1  packet-last flag; constant 1 (every ID is a single-beat packet).
- id_out_cfg_valid  out  1  ID offered to the cfg consumer.
- id_out_cfg_ready  in  1  cfg consumer accepts.
- id_out_buf_valid  out  1  ID offered to the buf consumer.
- id_out_buf_ready  in  1  buf consumer accepts.

## Operation

- State: id_q (ID_W), cfg_pend, buf_pend (channel still owes a handshake).
- id_out = id_q; id_out_cfg_valid = cfg_pend & en; id_out_buf_valid = buf_pend & en.
- cfg handshake hs_c = id_out_cfg_valid & id_out_cfg_ready; buf handshake hs_b likewise.
- Retire condition: (hs_c | ~cfg_pend) & (hs_b | ~buf_pend) & (hs_c | hs_b).
- On retire: id_q <= id_q + 1 (mod 2^ID_W, 63 -> 0), cfg_pend <= 1, buf_pend <= 1.
- Otherwise: hs_c clears cfg_pend; hs_b clears buf_pend; a channel whose pend is 0 holds valid low until the other channel completes.
- Sequence after reset: 0, 1, 2, ... 63, 0, ...; each value delivered exactly once per channel, in order.
- en = 0: valids low, no handshakes counted, id_q and pend flags hold; resume exactly where stopped.
- Ready is never required before valid; valid never depends combinationally on the channel's own ready.

## Timing

- Reset (sync_rst high at a clock edge): id_q = 0, cfg_pend = 1, buf_pend = 1. With en = 1 both valids are high and id_out = 0 in the first cycle after reset release; id_out_last = 1 always.
- Throughput: with both readies held high, one ID per cycle on each channel (back-to-back).
- Both handshakes in the same cycle: retire in that cycle; next cycle shows id+1 with both valids high.
- Staggered handshakes: first channel's valid drops the cycle after its handshake; ID advances the cycle after the second channel's handshake.
- Once asserted, a valid stays high with id_out stable until its handshake (AXI-Stream rule), except when en is deasserted.
- sync_rst mid-operation overrides any handshake in that cycle; partially delivered IDs are abandoned.

## Structure

- Shared package (sha256_pkg): ID_W default constant and id_t typedef, reused by the ID buffer and concatenator.
- Single flat module; no sub-module needed (per-channel pend logic is two symmetric always_ff terms).

## Test plan

- Reset, en = 1, both readies high -> IDs 0,1,2,...,63,0,1 on both channels, one per cycle, id_out_last = 1 on every beat.
- cfg ready high, buf ready low for 5 cycles -> cfg accepts ID 0 once, cfg valid low for the stall, ID stays 0 until buf accepts, then both show 1.
- Random independent stalls (0–7 cycles) on each ready over 200 IDs -> both channels receive the identical in-order sequence, no duplicates or gaps.
- en dropped for 4 cycles while buf has already taken ID 9 -> both valids low, no change; after en = 1 only cfg_valid high with ID 9, then 10 on both.
- sync_rst asserted while ID 37 is half-delivered -> next cycle id_out = 0, both valids high.
- Wrap: deliver 64 IDs -> id_out 63 followed by 0 without glitch on valid.
